// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg: shared defaults, FSM state type and counter-width helper
package byte_serializer_pkg;
  localparam int BYTE_PERIOD_DEF = 46;
  localparam int NBYTES_DEF = 5;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/byte_serializer_timer.sv
// byte_period_timer: counts 0..PERIOD-1 while running, flags the half point and terminal count
module byte_period_timer
  import byte_serializer_pkg::*;
#(
  parameter int PERIOD = BYTE_PERIOD_DEF
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tc,
  output logic half
);
  localparam int CW = clog2(PERIOD);
  logic [CW-1:0] cnt;
  assign tc = cnt == CW'(PERIOD - 1);
  assign half = cnt == CW'(PERIOD / 2 - 1);
  // restart wins over wrap so a back-to-back load starts a fresh period
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (restart) cnt <= '0;
    else if (run) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: captures an NBYTES word and emits it MSB byte first, one byte per BYTE_PERIOD clocks
// optional sticky overrun output enabled by BYTE_SERIALIZER_OVERRUN_EN
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int BYTE_PERIOD = BYTE_PERIOD_DEF,
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [NBYTES*8-1:0] din,
  input  logic                load,
  output logic                ready,
`ifdef BYTE_SERIALIZER_OVERRUN_EN
  output logic                overrun,
`endif
  output logic [7:0]          dout
);
  localparam int W = NBYTES * 8;
  localparam int RW = clog2(NBYTES + 1);
  state_t state;
  logic [W-1:0] sr, sh;
  logic [RW-1:0] rem;
  logic tc, half, last, accept;
  assign sh = sr << 8;
  assign last = tc && rem == RW'(1);
  assign accept = load && (state == IDLE || last);
  byte_period_timer #(.PERIOD(BYTE_PERIOD)) u_timer (
    .pclk(pclk),
    .rst_n(rst_n),
    .restart(accept),
    .run(state == SEND),
    .tc(tc),
    .half(half)
  );
  // serializer FSM: capture on accept, advance a byte at each terminal count, drop ready at half period
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      rem <= '0;
      dout <= '0;
      ready <= 1'b0;
    end else if (accept) begin
      state <= SEND;
      sr <= din;
      rem <= RW'(NBYTES);
      dout <= din[W-1 -: 8];
      ready <= 1'b1;
    end else if (state == SEND) begin
      if (tc && rem > RW'(1)) begin
        rem <= rem - 1'b1;
        sr <= sh;
        dout <= sh[W-1 -: 8];
        ready <= 1'b1;
      end else if (tc) begin
        state <= IDLE;
        rem <= '0;
        ready <= 1'b0;
      end else if (half) ready <= 1'b0;
    end
`ifdef BYTE_SERIALIZER_OVERRUN_EN
  // any load arriving mid-word is dropped and latched as an overrun
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) overrun <= 1'b0;
    else if (load && !accept) overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed + random stimulus against a per-cycle timing model of the serializer
module tb_byte_serializer;
  logic pclk, rst_n, load0, load1, ready0, ready1;
  logic [39:0] din0;
  logic [7:0] din1, dout0, dout1;
`ifdef BYTE_SERIALIZER_OVERRUN_EN
  logic ovr0, ovr1;
`endif
  int n_cmp, n_err, pulses;
  logic prev;
  logic [39:0] w;

  byte_serializer u0 (
    .pclk(pclk), .rst_n(rst_n), .din(din0), .load(load0), .ready(ready0),
`ifdef BYTE_SERIALIZER_OVERRUN_EN
    .overrun(ovr0),
`endif
    .dout(dout0)
  );
  byte_serializer #(.BYTE_PERIOD(3), .NBYTES(1)) u1 (
    .pclk(pclk), .rst_n(rst_n), .din(din1), .load(load1), .ready(ready1),
`ifdef BYTE_SERIALIZER_OVERRUN_EN
    .overrun(ovr1),
`endif
    .dout(dout1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // byte k of an n-byte word, k=0 being the most significant
  function automatic logic [7:0] mb(input logic [127:0] v, input int n, input int k);
    return 8'(v >> (8 * (n - 1 - k)));
  endfunction
  // expected dout t cycles after the load edge: current byte, then the last byte held
  function automatic logic [7:0] ed(input logic [127:0] v, input int p, input int n, input int t);
    return mb(v, n, (t / p < n) ? t / p : n - 1);
  endfunction
  function automatic logic er(input int p, input int n, input int t);
    return t < p * n && (t % p) < p / 2;
  endfunction

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [39:0] v, input int t0, input int t1, input bit ld);
    if (ld) begin
      din0 = v;
      load0 = 1'b1;
    end
    for (int t = t0; t < t1; t++) begin
      @(posedge pclk);
      #1;
      load0 = 1'b0;
      din0 = 40'({$urandom, $urandom});
      chk($sformatf("dout t=%0d", t), {32'd0, dout0}, {32'd0, ed(v, 46, 5, t)});
      chk($sformatf("ready t=%0d", t), {39'd0, ready0}, {39'd0, er(46, 5, t)});
      if (ready0 && !prev) pulses++;
      prev = ready0;
    end
  endtask

  task automatic run1(input logic [7:0] v, input int n);
    din1 = v;
    load1 = 1'b1;
    for (int t = 0; t < n; t++) begin
      @(posedge pclk);
      #1;
      load1 = 1'b0;
      din1 = 8'($urandom);
      chk($sformatf("dout1 t=%0d", t), {32'd0, dout1}, {32'd0, ed({120'd0, v}, 3, 1, t)});
      chk($sformatf("ready1 t=%0d", t), {39'd0, ready1}, {39'd0, er(3, 1, t)});
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pulses = 0; prev = 1'b0;
    rst_n = 1'b0; load0 = 1'b0; load1 = 1'b0; din0 = '0; din1 = '0;
    #1;
    chk("rst dout", {32'd0, dout0}, 40'd0);
    chk("rst ready", {39'd0, ready0}, 40'd0);
    repeat (3) @(posedge pclk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge pclk);
      #1;
      chk("idle dout", {32'd0, dout0}, 40'd0);
      chk("idle ready", {39'd0, ready0}, 40'd0);
      chk("idle dout1", {32'd0, dout1}, 40'd0);
    end
`ifdef BYTE_SERIALIZER_OVERRUN_EN
    chk("ovr reset", {39'd0, ovr0}, 40'd0);
`endif
    run(40'h1122334455, 0, 260, 1);
    chk("pulses basic", 40'(pulses), 40'd5);
    pulses = 0;
    run(40'h5566778899, 0, 230, 1);
    run(40'hAABBCCDDEE, 0, 260, 1);
    chk("pulses b2b", 40'(pulses), 40'd10);
    for (int i = 0; i < 3; i++) begin
      w = 40'({$urandom, $urandom});
      run(w, 0, 230 + 20 * i, 1);
    end
    w = 40'({$urandom, $urandom});
    run(w, 0, 60, 1);
`ifdef BYTE_SERIALIZER_OVERRUN_EN
    chk("ovr before", {39'd0, ovr0}, 40'd0);
`endif
    load0 = 1'b1;
    din0 = 40'hFFFFFFFFFF;
    run(w, 60, 61, 0);
`ifdef BYTE_SERIALIZER_OVERRUN_EN
    chk("ovr set", {39'd0, ovr0}, 40'd1);
`endif
    run(w, 61, 240, 0);
    w = 40'({$urandom, $urandom});
    run(w, 0, 100, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst dout", {32'd0, dout0}, 40'd0);
    chk("midrst ready", {39'd0, ready0}, 40'd0);
`ifdef BYTE_SERIALIZER_OVERRUN_EN
    chk("midrst ovr", {39'd0, ovr0}, 40'd0);
`endif
    repeat (2) @(posedge pclk);
    #1;
    rst_n = 1'b1;
    prev = 1'b0;
    pulses = 0;
    w = 40'({$urandom, $urandom});
    run(w, 0, 240, 1);
    chk("pulses after rst", 40'(pulses), 40'd5);
    run1(8'h5A, 5);
    run1(8'($urandom), 3);
    run1(8'h5A, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
